// File: rtl/snn_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_packet_pkg
// Description : Shared spike-packet definitions for the core mesh links:
//               link widths, packet field layout and the injector FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_packet_pkg;

    // Link widths of the router ports
    localparam int EW_WIDTH    = 30;
    localparam int NS_WIDTH    = 21;
    localparam int LOCAL_WIDTH = 12;

    // Field widths of an east/west packet
    localparam int DX_W   = 9;
    localparam int DY_W   = 9;
    localparam int AXON_W = 8;
    localparam int TICK_W = 4;

    // Field offsets (LSB positions) of an east/west packet
    localparam int TICK_LSB = 0;
    localparam int AXON_LSB = TICK_LSB + TICK_W;
    localparam int DY_LSB   = AXON_LSB + AXON_W;
    localparam int DX_LSB   = DY_LSB + DY_W;

    // Batch FSM of the injector
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Assemble an east/west packet from its fields
    function automatic logic [EW_WIDTH-1:0] make_packet(
        input logic [DX_W-1:0]   dx,
        input logic [DY_W-1:0]   dy,
        input logic [AXON_W-1:0] axon,
        input logic [TICK_W-1:0] tick
    );
        return {dx, dy, axon, tick};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is a
//               direct read at the registered read pointer; count and full
//               are registered. Callers only write when not full and only
//               read when count is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic [WIDTH-1:0]       o_head
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_full;
    logic [c_CNT_W-1:0]  w_count_nxt;

    // Occupancy after this cycle's write/read; a simultaneous pair cancels
    always_comb begin
        w_count_nxt = r_count;
        case ({i_wr_en, i_rd_en})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset since the head is masked when idle
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count and full track occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
        end
    end

    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mesh_spike_injector.sv
`default_nettype none
// ============================================================================
// Module      : mesh_spike_injector
// Description : Host-side spike transmitter for the west edge of the core
//               mesh. Host packets are queued in a FWFT FIFO; each tick
//               captures the current occupancy as a batch which is then
//               offered to the router over the empty/ren link.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_spike_injector
    import snn_packet_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int PACKET_WIDTH = EW_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_wen,
    input  logic [PACKET_WIDTH-1:0] host_packet,
    output logic                    host_full,
    input  logic                    tick,
    output logic [PACKET_WIDTH-1:0] dout,
    output logic                    empty_out,
    input  logic                    ren_in,
    output logic                    busy,
    output logic                    batch_done,
    output logic [15:0]             sent_count,
    output logic                    overflow_error,
    output logic                    underflow_error,
    output logic                    tick_overrun_error
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_batch_left;
    logic [c_CNT_W-1:0]      w_batch_left_nxt;
    logic                    r_empty_out;
    logic                    w_empty_out_nxt;
    logic                    r_busy;
    logic                    r_batch_done;
    logic                    w_batch_done_nxt;
    logic [15:0]             r_sent_count;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    r_overrun;

    logic [c_CNT_W-1:0]      w_count;
    logic                    w_full;
    logic [PACKET_WIDTH-1:0] w_head;
    logic                    w_push;
    logic                    w_pop;

    // A full FIFO drops the write even if a pop frees a slot this cycle
    assign w_push = host_wen & ~w_full;
    // Only reads against an offered packet move the read pointer
    assign w_pop  = ren_in & ~r_empty_out;

    spike_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PACKET_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (host_packet),
        .i_rd_en   (w_pop),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_head    (w_head)
    );

    // Batch FSM next state: capture occupancy on tick, count pops down to zero
    always_comb begin
        w_state_nxt      = r_state;
        w_batch_left_nxt = r_batch_left;
        w_batch_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (tick && (w_count != '0)) begin
                    w_state_nxt      = SEND;
                    w_batch_left_nxt = w_count;
                end
            end
            SEND: begin
                if (w_pop) begin
                    w_batch_left_nxt = r_batch_left - c_CNT_W'(1);
                    if (r_batch_left == c_CNT_W'(1)) begin
                        w_state_nxt      = IDLE;
                        w_batch_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_batch_left_nxt = '0;
            end
        endcase
        w_empty_out_nxt = (w_state_nxt == IDLE) || (w_batch_left_nxt == '0);
    end

    // FSM state and registered link/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_batch_left <= '0;
            r_empty_out  <= 1'b1;
            r_busy       <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_batch_left <= w_batch_left_nxt;
            r_empty_out  <= w_empty_out_nxt;
            r_busy       <= (w_state_nxt == SEND);
            r_batch_done <= w_batch_done_nxt;
        end
    end

    // Delivered-packet counter (wraps) and sticky protocol error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sent_count <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
            if (host_wen && w_full) begin
                r_overflow <= 1'b1;
            end
            if (ren_in && r_empty_out) begin
                r_underflow <= 1'b1;
            end
            if (tick && r_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign host_full          = w_full;
    assign dout               = r_empty_out ? '0 : w_head;
    assign empty_out          = r_empty_out;
    assign busy               = r_busy;
    assign batch_done         = r_batch_done;
    assign sent_count         = r_sent_count;
    assign overflow_error     = r_overflow;
    assign underflow_error    = r_underflow;
    assign tick_overrun_error = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mesh_spike_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_spike_injector
// Description : Directed self-checking bench for mesh_spike_injector with a
//               4-deep FIFO. Inputs change 1 ns after each rising edge and
//               outputs are checked there, reflecting that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_spike_injector;

    logic        clk;
    logic        reset;
    logic        host_wen;
    logic [29:0] host_packet;
    logic        host_full;
    logic        tick;
    logic [29:0] dout;
    logic        empty_out;
    logic        ren_in;
    logic        busy;
    logic        batch_done;
    logic [15:0] sent_count;
    logic        overflow_error;
    logic        underflow_error;
    logic        tick_overrun_error;

    int tests_run;
    int tests_failed;

    mesh_spike_injector #(
        .DEPTH        (4),
        .PACKET_WIDTH (30)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .host_wen           (host_wen),
        .host_packet        (host_packet),
        .host_full          (host_full),
        .tick               (tick),
        .dout               (dout),
        .empty_out          (empty_out),
        .ren_in             (ren_in),
        .busy               (busy),
        .batch_done         (batch_done),
        .sent_count         (sent_count),
        .overflow_error     (overflow_error),
        .underflow_error    (underflow_error),
        .tick_overrun_error (tick_overrun_error)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [29:0] pkt);
        host_wen    = 1'b1;
        host_packet = pkt;
        cyc();
        host_wen    = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".empty"},    32'(empty_out),          32'd1);
        chk({tag, ".dout"},     32'(dout),               32'd0);
        chk({tag, ".full"},     32'(host_full),          32'd0);
        chk({tag, ".busy"},     32'(busy),               32'd0);
        chk({tag, ".done"},     32'(batch_done),         32'd0);
        chk({tag, ".sent"},     32'(sent_count),         32'd0);
        chk({tag, ".ovf"},      32'(overflow_error),     32'd0);
        chk({tag, ".unf"},      32'(underflow_error),    32'd0);
        chk({tag, ".overrun"},  32'(tick_overrun_error), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        host_wen     = 1'b0;
        host_packet  = '0;
        tick         = 1'b0;
        ren_in       = 1'b0;
        #2;

        // ---------------- reset state
        do_reset();
        chk_reset_values("rst");

        // ---------------- single batch, continuous read
        wr(30'h0000_0010);
        wr(30'h0000_0021);
        wr(30'h0000_0032);
        chk("b1.idle_empty", 32'(empty_out), 32'd1);
        pulse_tick();
        chk("b1.offer_empty", 32'(empty_out), 32'd0);
        chk("b1.busy",        32'(busy),      32'd1);
        chk("b1.head0",       32'(dout),      32'h10);
        ren_in = 1'b1;
        cyc();
        chk("b1.head1",       32'(dout),      32'h21);
        chk("b1.done_early",  32'(batch_done), 32'd0);
        cyc();
        chk("b1.head2",       32'(dout),      32'h32);
        cyc();
        ren_in = 1'b0;
        chk("b1.end_empty",   32'(empty_out),  32'd1);
        chk("b1.end_busy",    32'(busy),       32'd0);
        chk("b1.done",        32'(batch_done), 32'd1);
        chk("b1.end_dout",    32'(dout),       32'd0);
        chk("b1.sent",        32'(sent_count), 32'd3);
        cyc();
        chk("b1.done_once",   32'(batch_done),      32'd0);
        chk("b1.no_unf",      32'(underflow_error), 32'd0);

        // ---------------- batch boundary
        do_reset();
        wr(30'h0000_0101);
        wr(30'h0000_0102);
        pulse_tick();
        chk("bb.head0", 32'(dout), 32'h101);
        host_wen    = 1'b1;
        host_packet = 30'h0000_0103;
        ren_in      = 1'b1;
        cyc();
        chk("bb.head1", 32'(dout), 32'h102);
        host_packet = 30'h0000_0104;
        cyc();
        host_wen = 1'b0;
        ren_in   = 1'b0;
        chk("bb.end_empty", 32'(empty_out),  32'd1);
        chk("bb.end_done",  32'(batch_done), 32'd1);
        chk("bb.sent2",     32'(sent_count), 32'd2);
        cyc();
        chk("bb.stay_idle", 32'(empty_out), 32'd1);
        chk("bb.idle_busy", 32'(busy),      32'd0);
        pulse_tick();
        chk("bb.head2", 32'(dout), 32'h103);
        ren_in = 1'b1;
        cyc();
        chk("bb.head3", 32'(dout), 32'h104);
        cyc();
        ren_in = 1'b0;
        chk("bb.done2", 32'(batch_done), 32'd1);
        chk("bb.sent4", 32'(sent_count), 32'd4);

        // ---------------- full FIFO (DEPTH = 4)
        do_reset();
        wr(30'h0000_0201);
        wr(30'h0000_0202);
        wr(30'h0000_0203);
        chk("ff.not_full3", 32'(host_full), 32'd0);
        wr(30'h0000_0204);
        chk("ff.full4",     32'(host_full),      32'd1);
        chk("ff.no_ovf4",   32'(overflow_error), 32'd0);
        wr(30'h0000_0205);
        chk("ff.full5",     32'(host_full),      32'd1);
        chk("ff.ovf",       32'(overflow_error), 32'd1);
        pulse_tick();
        chk("ff.head0", 32'(dout), 32'h201);
        ren_in = 1'b1;
        cyc();
        chk("ff.head1", 32'(dout), 32'h202);
        cyc();
        chk("ff.head2", 32'(dout), 32'h203);
        cyc();
        chk("ff.head3", 32'(dout), 32'h204);
        cyc();
        ren_in = 1'b0;
        chk("ff.done",      32'(batch_done),     32'd1);
        chk("ff.sent",      32'(sent_count),     32'd4);
        chk("ff.drained",   32'(host_full),      32'd0);
        chk("ff.ovf_stick", 32'(overflow_error), 32'd1);

        // ---------------- protocol violations
        do_reset();
        ren_in = 1'b1;
        cyc();
        ren_in = 1'b0;
        chk("pv.unf",       32'(underflow_error), 32'd1);
        chk("pv.unf_sent",  32'(sent_count),      32'd0);
        wr(30'h0000_0301);
        wr(30'h0000_0302);
        wr(30'h0000_0303);
        pulse_tick();
        chk("pv.head0", 32'(dout), 32'h301);
        ren_in = 1'b1;
        cyc();
        ren_in = 1'b0;
        chk("pv.head1", 32'(dout), 32'h302);
        chk("pv.no_overrun", 32'(tick_overrun_error), 32'd0);
        pulse_tick();
        chk("pv.overrun",   32'(tick_overrun_error), 32'd1);
        chk("pv.still_busy", 32'(busy),              32'd1);
        chk("pv.head1_hold", 32'(dout),              32'h302);
        ren_in = 1'b1;
        cyc();
        chk("pv.head2", 32'(dout), 32'h303);
        cyc();
        ren_in = 1'b0;
        chk("pv.done",  32'(batch_done), 32'd1);
        chk("pv.sent",  32'(sent_count), 32'd3);
        cyc();
        chk("pv.no_reload", 32'(empty_out),       32'd1);
        chk("pv.unf_stick", 32'(underflow_error), 32'd1);

        // ---------------- reset mid-batch
        do_reset();
        wr(30'h0000_0401);
        wr(30'h0000_0402);
        wr(30'h0000_0403);
        pulse_tick();
        ren_in = 1'b1;
        cyc();
        ren_in = 1'b0;
        chk("rm.head1", 32'(dout),       32'h402);
        chk("rm.sent1", 32'(sent_count), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset_values("rm");
        pulse_tick();
        chk("rm.tick_empty", 32'(empty_out), 32'd1);
        chk("rm.tick_busy",  32'(busy),      32'd0);

        // ---------------- simultaneous write and pop at count = 2
        do_reset();
        wr(30'h0000_0501);
        wr(30'h0000_0502);
        pulse_tick();
        chk("sw.head0", 32'(dout), 32'h501);
        host_wen    = 1'b1;
        host_packet = 30'h0000_0503;
        ren_in      = 1'b1;
        cyc();
        host_wen = 1'b0;
        chk("sw.head1", 32'(dout),      32'h502);
        chk("sw.full",  32'(host_full), 32'd0);
        cyc();
        ren_in = 1'b0;
        chk("sw.done1", 32'(batch_done), 32'd1);
        wr(30'h0000_0504);
        wr(30'h0000_0505);
        chk("sw.cnt3_full", 32'(host_full), 32'd0);
        wr(30'h0000_0506);
        chk("sw.cnt4_full", 32'(host_full), 32'd1);
        pulse_tick();
        chk("sw.head2", 32'(dout), 32'h503);
        ren_in = 1'b1;
        cyc();
        chk("sw.head3", 32'(dout), 32'h504);
        cyc();
        chk("sw.head4", 32'(dout), 32'h505);
        cyc();
        chk("sw.head5", 32'(dout), 32'h506);
        cyc();
        ren_in = 1'b0;
        chk("sw.done2", 32'(batch_done),      32'd1);
        chk("sw.sent",  32'(sent_count),      32'd6);
        chk("sw.ovf",   32'(overflow_error),  32'd0);
        chk("sw.unf",   32'(underflow_error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
